// File: rtl/multi_cen_gen.sv
// multi_cen_gen
// Multi-channel fractional clock-enable generator. Each channel is a phase
// accumulator (NCO) clocked by refclk. It emits a one-cycle cen pulse on every
// accumulator wrap, giving an average rate of f_refclk * inc / 2^ACC_W.
// A new increment is staged in a per-channel pending register. It is only
// committed when the channel wraps, or at once if the channel is idle
// (inc == 0), so a rate change never produces a short or split period.
// Optional feature: define CEN_HALF_EN to build the mid-period cen_half pulses.
// Otherwise cen_half is tied low.
module multi_cen_gen #(
  parameter int CHANNELS    = 2,
  parameter int ACC_W       = 24,
  parameter int LOCK_CYCLES = 16,
  parameter logic [CHANNELS*ACC_W-1:0] INIT_INC = {CHANNELS{ACC_W'(0)}},
  localparam int SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                refclk,
  input  logic                rst,
  input  logic                hold,
  input  logic                inc_wr,
  input  logic [SEL_W-1:0]    inc_sel,
  input  logic [ACC_W-1:0]    inc_data,
  output logic [CHANNELS-1:0] inc_busy,
  output logic [CHANNELS-1:0] cen,
  output logic [CHANNELS-1:0] cen_half,
  output logic                locked
);

  localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RESET,
    ST_LOCKING,
    ST_RUN
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  lock_cnt;
  logic [CNT_W-1:0]  lock_cnt_nxt;
  logic              lock_done;
  logic              advance;

  assign lock_done = (lock_cnt == LOCK_LAST);

  // Global state and lock counter registers; rst is the only way back to RESET.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state    <= ST_RESET;
      lock_cnt <= '0;
    end else begin
      state    <= state_nxt;
      lock_cnt <= lock_cnt_nxt;
    end
  end

  // Count out the lock interval, then park in RUN with the counter saturated.
  always_comb begin
    state_nxt    = state;
    lock_cnt_nxt = lock_cnt;
    case (state)
      ST_RESET, ST_LOCKING: begin
        if (lock_done) begin
          state_nxt = ST_RUN;
        end else begin
          state_nxt    = ST_LOCKING;
          lock_cnt_nxt = lock_cnt + CNT_W'(1);
        end
      end
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_RESET;
    endcase
  end

  assign locked  = (state == ST_RUN);
  assign advance = locked & ~hold;

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc;
    logic [ACC_W-1:0] pend;
    logic             pend_v;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic             wr_hit;
    logic             apply;
    logic             cen_r;

    assign sum    = {1'b0, acc} + {1'b0, inc};
    assign carry  = sum[ACC_W];
    assign wr_hit = inc_wr && (inc_sel == SEL_W'(n));
    assign apply  = advance && (carry || (inc == '0)) && pend_v;

    // Phase accumulator; the add on an apply cycle still uses the old increment.
    always_ff @(posedge refclk) begin
      if (rst) begin
        acc <= '0;
        inc <= INIT_INC[n*ACC_W +: ACC_W];
      end else if (advance) begin
        acc <= sum[ACC_W-1:0];
        if (apply) begin
          inc <= pend;
        end
      end
    end

    // Pending increment; a write in the same cycle as an apply keeps the slot busy.
    always_ff @(posedge refclk) begin
      if (rst) begin
        pend   <= '0;
        pend_v <= 1'b0;
      end else if (wr_hit) begin
        pend   <= inc_data;
        pend_v <= 1'b1;
      end else if (apply) begin
        pend_v <= 1'b0;
      end
    end

    // Registered enable: one pulse for every accumulator wrap while advancing.
    always_ff @(posedge refclk) begin
      if (rst) begin
        cen_r <= 1'b0;
      end else begin
        cen_r <= advance & carry;
      end
    end

    assign cen[n]      = cen_r;
    assign inc_busy[n] = pend_v;

`ifdef CEN_HALF_EN
    logic half_r;

    // Mid-period enable: the accumulator MSB rises without a wrap.
    always_ff @(posedge refclk) begin
      if (rst) begin
        half_r <= 1'b0;
      end else begin
        half_r <= advance & ~carry & ~acc[ACC_W-1] & sum[ACC_W-1];
      end
    end

    assign cen_half[n] = half_r;
`else
    assign cen_half[n] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_multi_cen_gen.sv
// tb_multi_cen_gen
// Self-checking bench for multi_cen_gen (ACC_W=8, CHANNELS=2, LOCK_CYCLES=4,
// INIT_INC={128,64}). Every cycle a behavioural model pushes the expected
// outputs into a scoreboard queue, and the value is popped once the DUT edge
// has happened. Each scenario task also checks its own explicit timing facts.
// The expectations track CEN_HALF_EN, matching the RTL build.
module tb_multi_cen_gen;
  localparam int CH = 2;
  localparam int AW = 8;
  localparam int LC = 4;
  localparam logic [15:0] INIT = {8'd128, 8'd64};

  logic       refclk   = 1'b0;
  logic       rst      = 1'b1;
  logic       hold     = 1'b0;
  logic       inc_wr   = 1'b0;
  logic [0:0] inc_sel  = 1'b0;
  logic [7:0] inc_data = 8'd0;
  logic [1:0] inc_busy;
  logic [1:0] cen;
  logic [1:0] cen_half;
  logic       locked;

  int total  = 0;
  int bad    = 0;
  int edge_n = 0;

  int m_acc[2];
  int m_inc[2];
  int m_pend[2];
  int m_cnt;
  bit m_pv[2];
  bit m_locked;
  logic [6:0] sb[$];

  always #5 refclk = ~refclk;

  multi_cen_gen #(
    .CHANNELS(CH), .ACC_W(AW), .LOCK_CYCLES(LC), .INIT_INC(INIT)
  ) dut (
    .refclk(refclk), .rst(rst), .hold(hold), .inc_wr(inc_wr),
    .inc_sel(inc_sel), .inc_data(inc_data), .inc_busy(inc_busy),
    .cen(cen), .cen_half(cen_half), .locked(locked)
  );

  function automatic logic [6:0] obs();
    return {cen, cen_half, inc_busy, locked};
  endfunction

  // Model the coming edge from the current inputs, queue the expectation,
  // clock once and hand back the expectation for this edge.
  task automatic step(output logic [6:0] e);
    int s;
    bit adv;
    bit cy;
    logic [6:0] x;
    x = '0;
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        m_acc[c] = 0; m_pend[c] = 0; m_pv[c] = 0;
      end
      m_inc[0] = int'(INIT[7:0]);
      m_inc[1] = int'(INIT[15:8]);
      m_cnt = 0;
      m_locked = 0;
    end else begin
      adv = m_locked && !hold;
      for (int c = 0; c < 2; c++) begin
        s  = m_acc[c] + m_inc[c];
        cy = (s >= 256);
        x[5+c] = adv && cy;
`ifdef CEN_HALF_EN
        x[3+c] = adv && !cy && (m_acc[c] < 128) && (s >= 128);
`endif
        if (adv) begin
          if ((cy || m_inc[c] == 0) && m_pv[c]) begin
            m_inc[c] = m_pend[c];
            m_pv[c]  = 0;
          end
          m_acc[c] = s % 256;
        end
        if (inc_wr && int'(inc_sel) == c) begin
          m_pend[c] = int'(inc_data);
          m_pv[c]   = 1;
        end
        x[1+c] = m_pv[c];
      end
      if (m_cnt == LC - 1) m_locked = 1;
      else m_cnt++;
      x[0] = m_locked;
    end
    sb.push_back(x);
    @(posedge refclk);
    #1;
    edge_n++;
    e = sb.pop_front();
  endtask

  task automatic test_reset();
    logic [6:0] e;
    rst = 1; hold = 0; inc_wr = 0;
    for (int i = 0; i < 2; i++) begin
      step(e); total++;
      if (obs() !== e) begin bad++; $display("[TB] FAIL reset_sb got=%b exp=%b", obs(), e); end
    end
    total++;
    if ({cen, cen_half, inc_busy, locked} !== 7'd0)
      begin bad++; $display("[TB] FAIL reset_outputs got=%b exp=0000000", obs()); end
    edge_n = 0;
  endtask

  task automatic test_lock(input string name);
    logic [6:0] e;
    int first_lock = -1;
    int early = 0;
    int bad0 = 0;
    int bad1 = 0;
    rst = 0;
    while (edge_n < 40) begin
      step(e); total++;
      if (obs() !== e) begin bad++; $display("[TB] FAIL %s_sb edge=%0d got=%b exp=%b", name, edge_n, obs(), e); end
      if (locked && first_lock < 0) first_lock = edge_n;
      if (!locked && cen != 2'b00) early++;
      if (cen[0] !== (edge_n >= 8 && (edge_n - 8) % 4 == 0)) bad0++;
      if (cen[1] !== (edge_n >= 6 && edge_n % 2 == 0)) bad1++;
    end
    total++;
    if (first_lock != 4) begin bad++; $display("[TB] FAIL %s_lock_edge got=%0d exp=4", name, first_lock); end
    total++;
    if (early != 0) begin bad++; $display("[TB] FAIL %s_cen_before_lock got=%0d exp=0", name, early); end
    total++;
    if (bad0 != 0) begin bad++; $display("[TB] FAIL %s_ch0_period4 wrong_cycles=%0d exp=0", name, bad0); end
    total++;
    if (bad1 != 0) begin bad++; $display("[TB] FAIL %s_ch1_period2 wrong_cycles=%0d exp=0", name, bad1); end
  endtask

  task automatic test_switch();
    logic [6:0] e;
    int miss = 0;
    while (edge_n < 60) begin
      inc_wr = (edge_n == 41); inc_sel = 1'b0; inc_data = 8'd32;
      step(e); total++;
      if (obs() !== e) begin bad++; $display("[TB] FAIL switch_sb edge=%0d got=%b exp=%b", edge_n, obs(), e); end
      if (edge_n == 42 || edge_n == 43) begin
        total++;
        if (inc_busy[0] !== 1'b1) begin bad++; $display("[TB] FAIL switch_busy_set edge=%0d got=%b exp=1", edge_n, inc_busy[0]); end
      end
      if (edge_n == 44) begin
        total++;
        if (inc_busy[0] !== 1'b0) begin bad++; $display("[TB] FAIL switch_busy_clr got=%b exp=0", inc_busy[0]); end
      end
      if (cen[0] !== (edge_n == 44 || edge_n == 52 || edge_n == 60)) miss++;
    end
    inc_wr = 0;
    total++;
    if (miss != 0) begin bad++; $display("[TB] FAIL switch_pulse_times wrong_cycles=%0d exp=0", miss); end
  endtask

  task automatic test_zero_inc();
    logic [6:0] e;
    int quiet = 0;
    int pulses = 0;
    int bad_iv = 0;
    int last = -1;
    int first = -1;
    while (edge_n < 332) begin
      inc_wr = (edge_n == 60) || (edge_n == 74); inc_sel = 1'b0;
      inc_data = (edge_n == 74) ? 8'd85 : 8'd0;
      step(e); total++;
      if (obs() !== e) begin bad++; $display("[TB] FAIL zero_sb edge=%0d got=%b exp=%b", edge_n, obs(), e); end
      if (edge_n >= 69 && edge_n <= 76 && cen[0]) quiet++;
      if (edge_n == 75) begin
        total++;
        if (inc_busy[0] !== 1'b1) begin bad++; $display("[TB] FAIL zero_busy_set got=%b exp=1", inc_busy[0]); end
      end
      if (edge_n == 76) begin
        total++;
        if (inc_busy[0] !== 1'b0) begin bad++; $display("[TB] FAIL zero_apply_now got=%b exp=0", inc_busy[0]); end
      end
      if (edge_n >= 77 && cen[0]) begin
        pulses++;
        if (first < 0) first = edge_n;
        if (last >= 0 && (edge_n - last < 3 || edge_n - last > 4)) bad_iv++;
        last = edge_n;
      end
    end
    inc_wr = 0;
    total++;
    if (quiet != 0) begin bad++; $display("[TB] FAIL zero_inc_silent got=%0d exp=0", quiet); end
    total++;
    if (first != 80) begin bad++; $display("[TB] FAIL inc85_first_pulse got=%0d exp=80", first); end
    total++;
    if (pulses != 85) begin bad++; $display("[TB] FAIL inc85_rate got=%0d exp=85", pulses); end
    total++;
    if (bad_iv != 0) begin bad++; $display("[TB] FAIL inc85_intervals bad=%0d exp=0", bad_iv); end
  endtask

  task automatic test_hold();
    logic [6:0] e;
    int held = 0;
    int resume = -1;
    while (edge_n < 350) begin
      hold = (edge_n >= 333 && edge_n <= 342);
      step(e); total++;
      if (obs() !== e) begin bad++; $display("[TB] FAIL hold_sb edge=%0d got=%b exp=%b", edge_n, obs(), e); end
      if (edge_n >= 334 && edge_n <= 343 && (cen != 2'b00 || cen_half != 2'b00)) held++;
      if (edge_n >= 344 && cen[0] && resume < 0) resume = edge_n;
    end
    hold = 0;
    total++;
    if (held != 0) begin bad++; $display("[TB] FAIL hold_no_cen got=%0d exp=0", held); end
    total++;
    if (resume != 346) begin bad++; $display("[TB] FAIL hold_phase got=%0d exp=346", resume); end
  endtask

  task automatic test_back_to_back();
    logic [6:0] e;
    int pulses = 0;
    while (edge_n < 374) begin
      hold = (edge_n == 350 || edge_n == 351);
      inc_wr = (edge_n == 350 || edge_n == 351); inc_sel = 1'b1;
      inc_data = (edge_n == 350) ? 8'd16 : 8'd255;
      step(e); total++;
      if (obs() !== e) begin bad++; $display("[TB] FAIL b2b_sb edge=%0d got=%b exp=%b", edge_n, obs(), e); end
      if (edge_n == 353) begin
        total++;
        if (inc_busy[1] !== 1'b1) begin bad++; $display("[TB] FAIL b2b_busy got=%b exp=1", inc_busy[1]); end
      end
      if (edge_n == 354) begin
        total++;
        if (inc_busy[1] !== 1'b0) begin bad++; $display("[TB] FAIL b2b_applied got=%b exp=0", inc_busy[1]); end
      end
      if (edge_n >= 356 && cen[1]) pulses++;
    end
    hold = 0; inc_wr = 0;
    total++;
    if (pulses != 19) begin bad++; $display("[TB] FAIL b2b_last_wins got=%0d exp=19", pulses); end
  endtask

  task automatic test_reset_busy();
    logic [6:0] e;
    hold = 1;
    for (int i = 0; i < 2; i++) begin
      inc_wr = 1; inc_sel = (i == 0) ? 1'b1 : 1'b0; inc_data = 8'd16;
      step(e); total++;
      if (obs() !== e) begin bad++; $display("[TB] FAIL rstbusy_sb edge=%0d got=%b exp=%b", edge_n, obs(), e); end
    end
    total++;
    if (inc_busy !== 2'b11) begin bad++; $display("[TB] FAIL rstbusy_pending got=%b exp=11", inc_busy); end
    inc_wr = 0; hold = 0; rst = 1;
    step(e); total++;
    if (obs() !== e) begin bad++; $display("[TB] FAIL rstbusy_sb_rst got=%b exp=%b", obs(), e); end
    total++;
    if ({inc_busy, locked, cen} !== 5'd0)
      begin bad++; $display("[TB] FAIL rstbusy_cleared busy=%b locked=%b cen=%b exp=0", inc_busy, locked, cen); end
    step(e);
    edge_n = 0;
  endtask

  task automatic test_cen_half();
    logic [6:0] e;
    logic d1 = 1'b0;
    logic d2 = 1'b0;
    logic exp_h;
    int wrong = 0;
    int halves = 0;
    int exp_halves;
    rst = 1;
    for (int i = 0; i < 2; i++) step(e);
    edge_n = 0; rst = 0;
    while (edge_n < 40) begin
      step(e); total++;
      if (obs() !== e) begin bad++; $display("[TB] FAIL half_sb edge=%0d got=%b exp=%b", edge_n, obs(), e); end
`ifdef CEN_HALF_EN
      exp_h = d2;
`else
      exp_h = 1'b0;
`endif
      if (edge_n >= 7) begin
        if (cen_half[0] !== exp_h) wrong++;
        if (cen_half[0]) halves++;
      end
      d2 = d1; d1 = cen[0];
    end
`ifdef CEN_HALF_EN
    exp_halves = 8;
`else
    exp_halves = 0;
`endif
    total++;
    if (wrong != 0) begin bad++; $display("[TB] FAIL half_after_cen wrong_cycles=%0d exp=0", wrong); end
    total++;
    if (halves != exp_halves) begin bad++; $display("[TB] FAIL half_count got=%0d exp=%0d", halves, exp_halves); end
  endtask

  initial begin
    test_reset();
    test_lock("lock");
    test_switch();
    test_zero_inc();
    test_hold();
    test_back_to_back();
    test_reset_busy();
    test_lock("relock");
    test_cen_half();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
